// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with IDLE/FETCH/HOLD FSM and one-entry redirect buffer.
// Define FETCH_EXC_EN to add the ExcReq port and EXC_VEC exception redirect.
module fetch_ctrl #(
  parameter logic [31:2] RESET_PC = 30'h00100000
`ifdef FETCH_EXC_EN
  , parameter logic [31:2] EXC_VEC = 30'h00100060
`endif
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        JTaken,
  input  logic [31:2] JTarget,
  input  logic        BrTaken,
  input  logic [31:2] BrTarget,
`ifdef FETCH_EXC_EN
  input  logic        ExcReq,
`endif
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic        ImemReq,
  output logic [31:2] ImemAddr,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:2] PC
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t      r_state;
  logic        r_redir_pend;
  logic [31:2] r_redir_tgt;
  logic        w_redir;
  logic [31:2] w_tgt;
`ifdef FETCH_EXC_EN
  assign w_redir = ExcReq | JTaken | BrTaken;
  assign w_tgt   = ExcReq ? EXC_VEC : JTaken ? JTarget : BrTarget;
`else
  assign w_redir = JTaken | BrTaken;
  assign w_tgt   = JTaken ? JTarget : BrTarget;
`endif
  assign ImemAddr = PC;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      PC           <= RESET_PC;
      ImemReq      <= 1'b0;
      InstrValid   <= 1'b0;
      Instr        <= 32'h0;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_redir) PC <= w_tgt;
          r_state <= FETCH;
          ImemReq <= 1'b1;
        end
        FETCH: begin
          if (!ImemAck) begin
            if (w_redir) begin
              r_redir_pend <= 1'b1;
              r_redir_tgt  <= w_tgt;
            end
          end else if (!w_redir && !r_redir_pend) begin
            Instr      <= ImemRdata;
            InstrValid <= 1'b1;
            ImemReq    <= 1'b0;
            r_state    <= HOLD;
          end else begin
            // a redirect arriving with the ack beats the buffered target
            PC           <= w_redir ? w_tgt : r_redir_tgt;
            r_redir_pend <= 1'b0;
            ImemReq      <= 1'b0;
            r_state      <= IDLE;
          end
        end
        HOLD: begin
          if (w_redir || !Stall) begin
            PC         <= w_redir ? w_tgt : PC + 30'd1;
            InstrValid <= 1'b0;
            ImemReq    <= 1'b1;
            r_state    <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
          ImemReq <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        JTaken = 1'b0;
  logic [31:2] JTarget = '0;
  logic        BrTaken = 1'b0;
  logic [31:2] BrTarget = '0;
`ifdef FETCH_EXC_EN
  logic        ExcReq = 1'b0;
`endif
  logic        ImemAck = 1'b0;
  logic [31:0] ImemRdata = '0;
  logic        ImemReq;
  logic [31:2] ImemAddr;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:2] PC;
  int n_cmp = 0;
  int n_bad = 0;

  fetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .JTaken(JTaken), .JTarget(JTarget), .BrTaken(BrTaken), .BrTarget(BrTarget),
`ifdef FETCH_EXC_EN
    .ExcReq(ExcReq),
`endif
    .ImemAck(ImemAck), .ImemRdata(ImemRdata), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .Instr(Instr), .InstrValid(InstrValid), .PC(PC)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; ImemAck = 1'b1; JTaken = 1'b1; JTarget = 30'h00000123;
    cyc(); cyc();
    Reset = 1'b0; ImemAck = 1'b0; JTaken = 1'b0;
    n_cmp++; if (PC !== 30'h00100000) begin n_bad++; $display("FAIL reset_pc got %h want %h", PC, 30'h00100000); end
    n_cmp++; if (ImemReq !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", ImemReq); end
    n_cmp++; if (InstrValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", InstrValid); end
    n_cmp++; if (Instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0", Instr); end
  endtask

  task automatic test_first_fetch();
    cyc();
    n_cmp++; if (ImemReq !== 1'b1) begin n_bad++; $display("FAIL ff_req got %b want 1", ImemReq); end
    n_cmp++; if (ImemAddr !== 30'h00100000) begin n_bad++; $display("FAIL ff_addr got %h want %h", ImemAddr, 30'h00100000); end
    ImemAck = 1'b1; ImemRdata = 32'h20080005;
    cyc();
    ImemAck = 1'b0;
    n_cmp++; if (Instr !== 32'h20080005) begin n_bad++; $display("FAIL ff_instr got %h want %h", Instr, 32'h20080005); end
    n_cmp++; if (InstrValid !== 1'b1) begin n_bad++; $display("FAIL ff_valid got %b want 1", InstrValid); end
    n_cmp++; if (ImemReq !== 1'b0) begin n_bad++; $display("FAIL ff_req_drop got %b want 0", ImemReq); end
  endtask

  task automatic test_stall();
    Stall = 1'b1; ImemAck = 1'b1; ImemRdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (PC !== 30'h00100000 || InstrValid !== 1'b1 || Instr !== 32'h20080005 || ImemReq !== 1'b0)
        begin n_bad++; $display("FAIL stall_hold%0d got pc=%h v=%b i=%h r=%b want pc=00100000 v=1 i=20080005 r=0", i, PC, InstrValid, Instr, ImemReq); end
    end
    Stall = 1'b0; ImemAck = 1'b0;
    cyc();
    n_cmp++; if (PC !== 30'h00100001) begin n_bad++; $display("FAIL stall_release_pc got %h want %h", PC, 30'h00100001); end
    n_cmp++; if (ImemReq !== 1'b1 || InstrValid !== 1'b0) begin n_bad++; $display("FAIL stall_release_rv got r=%b v=%b want r=1 v=0", ImemReq, InstrValid); end
  endtask

  task automatic test_branch_pending();
    BrTaken = 1'b1; BrTarget = 30'h00100010;
    cyc();
    BrTaken = 1'b0;
    n_cmp++; if (ImemAddr !== 30'h00100001 || ImemReq !== 1'b1) begin n_bad++; $display("FAIL br_wait1 got a=%h r=%b want a=00100001 r=1", ImemAddr, ImemReq); end
    cyc();
    n_cmp++; if (ImemAddr !== 30'h00100001 || ImemReq !== 1'b1) begin n_bad++; $display("FAIL br_wait2 got a=%h r=%b want a=00100001 r=1", ImemAddr, ImemReq); end
    ImemAck = 1'b1; ImemRdata = 32'hDEADBEEF;
    cyc();
    ImemAck = 1'b0;
    n_cmp++; if (PC !== 30'h00100010) begin n_bad++; $display("FAIL br_pc got %h want %h", PC, 30'h00100010); end
    n_cmp++; if (InstrValid !== 1'b0 || ImemReq !== 1'b0) begin n_bad++; $display("FAIL br_discard got v=%b r=%b want v=0 r=0", InstrValid, ImemReq); end
    cyc();
    n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 30'h00100010) begin n_bad++; $display("FAIL br_refetch got r=%b a=%h want r=1 a=00100010", ImemReq, ImemAddr); end
  endtask

  task automatic test_pending_overwrite();
    BrTaken = 1'b1; BrTarget = 30'h00000aaa;
    cyc();
    BrTaken = 1'b0; JTaken = 1'b1; JTarget = 30'h00000bbb;
    cyc();
    JTaken = 1'b0; ImemAck = 1'b1;
    cyc();
    ImemAck = 1'b0;
    n_cmp++; if (PC !== 30'h00000bbb) begin n_bad++; $display("FAIL overwrite_pc got %h want %h", PC, 30'h00000bbb); end
    cyc();
    n_cmp++; if (ImemReq !== 1'b1) begin n_bad++; $display("FAIL overwrite_refetch got %b want 1", ImemReq); end
  endtask

  task automatic test_priority();
    ImemAck = 1'b1; ImemRdata = 32'h11111111;
    cyc();
    ImemAck = 1'b0;
    n_cmp++; if (InstrValid !== 1'b1 || Instr !== 32'h11111111) begin n_bad++; $display("FAIL prio_hold got v=%b i=%h want v=1 i=11111111", InstrValid, Instr); end
    Stall = 1'b1; JTaken = 1'b1; JTarget = 30'h00100020; BrTaken = 1'b1; BrTarget = 30'h00100030;
    cyc();
    Stall = 1'b0; JTaken = 1'b0; BrTaken = 1'b0;
    n_cmp++; if (PC !== 30'h00100020) begin n_bad++; $display("FAIL prio_pc got %h want %h", PC, 30'h00100020); end
    n_cmp++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1) begin n_bad++; $display("FAIL prio_state got v=%b r=%b want v=0 r=1", InstrValid, ImemReq); end
  endtask

  task automatic test_wrap();
    ImemAck = 1'b1;
    cyc();
    ImemAck = 1'b0; Stall = 1'b1; JTaken = 1'b1; JTarget = 30'h3FFFFFFF;
    cyc();
    JTaken = 1'b0; Stall = 1'b0; ImemAck = 1'b1;
    cyc();
    ImemAck = 1'b0;
    n_cmp++; if (PC !== 30'h3FFFFFFF || InstrValid !== 1'b1) begin n_bad++; $display("FAIL wrap_setup got pc=%h v=%b want pc=3fffffff v=1", PC, InstrValid); end
    cyc();
    n_cmp++; if (PC !== 30'h00000000 || ImemReq !== 1'b1) begin n_bad++; $display("FAIL wrap_pc got pc=%h r=%b want pc=00000000 r=1", PC, ImemReq); end
  endtask

  task automatic test_redirect_at_ack();
    ImemAck = 1'b1; JTaken = 1'b1; JTarget = 30'h00200000; ImemRdata = 32'h12345678;
    cyc();
    ImemAck = 1'b0; JTaken = 1'b0;
    n_cmp++; if (PC !== 30'h00200000 || InstrValid !== 1'b0 || ImemReq !== 1'b0) begin n_bad++; $display("FAIL ackredir got pc=%h v=%b r=%b want pc=00200000 v=0 r=0", PC, InstrValid, ImemReq); end
    BrTaken = 1'b1; BrTarget = 30'h00300000;
    cyc();
    BrTaken = 1'b0;
    n_cmp++; if (PC !== 30'h00300000 || ImemReq !== 1'b1) begin n_bad++; $display("FAIL idle_redir got pc=%h r=%b want pc=00300000 r=1", PC, ImemReq); end
  endtask

  task automatic test_reset_mid_fetch();
    Reset = 1'b1; ImemAck = 1'b1;
    cyc();
    Reset = 1'b0;
    n_cmp++; if (PC !== 30'h00100000 || InstrValid !== 1'b0 || ImemReq !== 1'b0) begin n_bad++; $display("FAIL rstmid got pc=%h v=%b r=%b want pc=00100000 v=0 r=0", PC, InstrValid, ImemReq); end
    cyc();
    ImemAck = 1'b0;
    n_cmp++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle_ack got v=%b r=%b want v=0 r=1", InstrValid, ImemReq); end
    cyc();
    n_cmp++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1 || PC !== 30'h00100000) begin n_bad++; $display("FAIL rstmid_wait got v=%b r=%b pc=%h want v=0 r=1 pc=00100000", InstrValid, ImemReq, PC); end
  endtask

`ifdef FETCH_EXC_EN
  task automatic test_exc();
    ImemAck = 1'b1;
    cyc();
    ImemAck = 1'b0; ExcReq = 1'b1; JTaken = 1'b1; JTarget = 30'h00100020;
    cyc();
    ExcReq = 1'b0; JTaken = 1'b0;
    n_cmp++; if (PC !== 30'h00100060) begin n_bad++; $display("FAIL exc_pc got %h want %h", PC, 30'h00100060); end
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    n_cmp++; if (PC !== 30'h00100000 || InstrValid !== 1'b0) begin n_bad++; $display("FAIL exc_rst got pc=%h v=%b want pc=00100000 v=0", PC, InstrValid); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch_pending();
    test_pending_overwrite();
    test_priority();
    test_wrap();
    test_redirect_at_ack();
    test_reset_mid_fetch();
`ifdef FETCH_EXC_EN
    test_exc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 30'h00100000, word address loaded into PC on reset (byte 0x00400000).
REQ-002 Parameter EXC_VEC, default 30'h00100060, word address of the exception handler; present only under FETCH_EXC_EN.
REQ-003 Clk  in  1  sole clock; all state changes on posedge Clk.
REQ-004 Reset  in  1  synchronous, active-high reset, sampled on posedge Clk only.
REQ-005 Stall  in  1  decode/execute not ready to consume Instr.
REQ-006 JTaken  in  1  jump redirect request; JTarget  in  [31:2]  jump target word address.
REQ-007 BrTaken  in  1  branch redirect request; BrTarget  in  [31:2]  branch target word address.
REQ-008 ImemAck  in  1  instruction memory has returned data; ImemRdata  in  32  returned instruction word.
REQ-009 ImemReq  out  1  fetch request to instruction memory; ImemAddr  out  [31:2]  fetch word address.
REQ-010 Instr  out  32  fetched instruction; InstrValid  out  1  Instr holds a valid, non-squashed word.
REQ-011 PC  out  [31:2]  word address of the instruction being fetched or held.

Function
REQ-012 The block SHALL implement three states: IDLE, FETCH and HOLD, plus a one-entry redirect buffer (RedirPend flag, RedirTgt [31:2]).
REQ-013 ImemAddr SHALL equal PC at all times; ImemReq SHALL be 1 exactly when the state is FETCH.
REQ-014 IDLE: on the next edge go to FETCH; a redirect in IDLE SHALL load its target into PC directly.
REQ-015 FETCH without ImemAck: PC and ImemReq SHALL hold stable; a redirect SHALL set RedirPend and write RedirTgt (a later redirect overwrites an earlier one).
REQ-016 FETCH with ImemAck, no redirect this cycle and RedirPend=0: Instr<=ImemRdata, InstrValid<=1, go to HOLD.
REQ-017 FETCH with ImemAck and a redirect this cycle or RedirPend=1: data SHALL be discarded (InstrValid stays 0), PC<=new target (this-cycle redirect wins over RedirTgt), RedirPend<=0, go to IDLE.
REQ-018 HOLD with a redirect: PC<=target, InstrValid<=0, go to FETCH, regardless of Stall.
REQ-019 HOLD, no redirect, Stall=0: PC<=PC+1, InstrValid<=0, go to FETCH; Stall=1: all outputs hold.
REQ-020 Redirect priority SHALL be JTaken over BrTaken (exception above both when enabled).
REQ-021 PC increment SHALL be 30-bit modulo: 30'h3FFFFFFF+1 -> 30'h00000000.
REQ-022 Fetch-to-valid latency SHALL be one cycle after the ImemAck edge; ImemAck outside FETCH SHALL be ignored.

Reset
REQ-023 Reset SHALL override all other inputs in the same edge: state=IDLE, PC=RESET_PC, ImemReq=0, InstrValid=0, Instr=32'h0, RedirPend=0, RedirTgt=0.
REQ-024 Reset asserted mid-fetch SHALL abandon the outstanding request; a following ImemAck in IDLE SHALL be ignored.

Configuration
REQ-025 With macro FETCH_EXC_EN defined, an ExcReq input (1 bit) and EXC_VEC SHALL exist; ExcReq is treated as a highest-priority redirect to EXC_VEC under REQ-014..REQ-018.
REQ-026 Without FETCH_EXC_EN, the ExcReq port and EXC_VEC SHALL be absent, and behaviour SHALL be identical to the enabled build with ExcReq=0.

Verification
REQ-027 Reset, then ImemAck with ImemRdata=32'h20080005 one cycle after ImemReq rises -> ImemAddr=30'h00100000, next cycle Instr=32'h20080005 and InstrValid=1.
REQ-028 HOLD with Stall=1 for 3 cycles, then Stall=0 -> outputs frozen 3 cycles, then PC=30'h00100001 and ImemReq=1.
REQ-029 BrTaken=1, BrTarget=30'h00100010 during FETCH with ImemAck low for 2 cycles -> ImemAddr stays put; data at the ack is discarded; PC=30'h00100010; a new fetch follows.
REQ-030 JTaken and BrTaken together in HOLD (JTarget=30'h00100020, BrTarget=30'h00100030) -> PC=30'h00100020.
REQ-031 PC=30'h3FFFFFFF, HOLD, Stall=0 -> PC=30'h00000000.
REQ-032 FETCH_EXC_EN build: ExcReq with JTaken in HOLD -> PC=EXC_VEC; Reset mid-FETCH -> PC=30'h00100000, InstrValid=0.
